// File: rtl/flags_stack.sv
// LIFO of ALU condition flags {O,S,Z,C}: pushed on trap entry, popped on return,
// with the popped value held on flags_restore/flags_we until the ALU takes it.
module flags_stack #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       flags,
  input  logic             bubble,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  output logic [31:0]      flags_restore,
  output logic             flags_we,
  output logic [3:0]       top_flags,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             overflow_err,
  output logic             underflow_err
);

  logic [3:0]       mem [DEPTH];

  logic [PTR_W:0]   count_reg, count_next;
  logic [31:0]      restore_reg, restore_next;
  logic             we_reg, we_next;
  logic             ovf_reg, ovf_next;
  logic             unf_reg, unf_next;

  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W:0]   count_m1;
  logic [PTR_W-1:0] top_idx;

  assign count_m1 = count_reg - 1'b1;
  assign top_idx  = count_m1[PTR_W-1:0];
  assign full     = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty    = (count_reg == '0);

  always_comb begin
    count_next   = count_reg;
    restore_next = restore_reg;
    // A pending restore survives only edges where the stage is held.
    we_next      = we_reg & bubble;
    ovf_next     = ovf_reg & ~err_clr;
    unf_next     = unf_reg & ~err_clr;
    wr_en        = 1'b0;
    wr_idx       = count_reg[PTR_W-1:0];

    if (!bubble) begin
      if (pop) begin
        if (empty) begin
          unf_next = 1'b1;
        end else begin
          restore_next = {28'b0, mem[top_idx]};
          we_next      = 1'b1;
        end
      end

      if (push) begin
        if (pop && !empty) begin
          // Nested trap on return: the popped slot is reused, depth unchanged.
          wr_en  = 1'b1;
          wr_idx = top_idx;
        end else if (full) begin
          ovf_next = 1'b1;
        end else begin
          wr_en      = 1'b1;
          wr_idx     = count_reg[PTR_W-1:0];
          count_next = count_reg + 1'b1;
        end
      end else if (pop && !empty) begin
        count_next = count_m1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg   <= '0;
      restore_reg <= '0;
      we_reg      <= 1'b0;
      ovf_reg     <= 1'b0;
      unf_reg     <= 1'b0;
    end else begin
      count_reg   <= count_next;
      restore_reg <= restore_next;
      we_reg      <= we_next;
      ovf_reg     <= ovf_next;
      unf_reg     <= unf_next;
    end
  end

  // Per-entry write ports; contents are not reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (!rst && wr_en && (wr_idx == PTR_W'(gi))) begin
          mem[gi] <= flags;
        end
      end
    end
  endgenerate

  assign top_flags     = empty ? 4'b0 : mem[top_idx];
  assign count         = count_reg;
  assign flags_restore = restore_reg;
  assign flags_we      = we_reg;
  assign overflow_err  = ovf_reg;
  assign underflow_err = unf_reg;

endmodule
